// File: rtl/sram_dp_arbiter.sv
// Round-robin dual-port arbiter in front of one SRAM2S_1024X16 array.
// Grants up to two requesters per cycle (first -> port 0, second -> port 1),
// blocks same-address hazards involving a write, and routes read data back
// to the requester that issued the read one cycle earlier.
module sram_dp_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned AW   = 10,
  parameter int unsigned DW   = 16
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ-1:0]    req_we,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_wdata,
  output logic [NREQ-1:0]    rsp_valid,
  output logic [NREQ*DW-1:0] rsp_data,
  output logic               CE0,
  output logic [AW-1:0]      A0,
  output logic [DW-1:0]      D0,
  output logic               WE0,
  output logic [DW-1:0]      WEM0,
  input  logic [DW-1:0]      Q0,
  output logic               CE1,
  output logic [AW-1:0]      A1,
  output logic [DW-1:0]      D1,
  output logic               WE1,
  output logic [DW-1:0]      WEM1,
  input  logic [DW-1:0]      Q1
);

  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0] rr_ptr;
  logic          v0, v1;
  logic [PW-1:0] id0, id1;

  logic          f0, f1;
  logic [PW-1:0] g0, g1;
  logic [AW-1:0] a_g0, a_g1;
  logic [DW-1:0] d_g0, d_g1;
  logic          we_g0, we_g1;
  logic          conflict;
  logic          gnt0, gnt1;

  // (base + k) mod NREQ; base < NREQ and k < NREQ so one subtraction suffices
  function automatic logic [PW-1:0] wrap(input logic [PW-1:0] base,
                                         input int unsigned k);
    int unsigned s;
    s = 32'(base) + k;
    if (s >= NREQ) s = s - NREQ;
    return PW'(s);
  endfunction

  // Round-robin scan from rr_ptr: first valid -> g0, next valid -> g1
  always_comb begin : grant_scan
    logic [PW-1:0] idx;
    f0  = 1'b0;
    f1  = 1'b0;
    g0  = '0;
    g1  = '0;
    idx = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = wrap(rr_ptr, k);
      if (req_valid[idx]) begin
        if (!f0) begin
          f0 = 1'b1;
          g0 = idx;
        end else if (!f1) begin
          f1 = 1'b1;
          g1 = idx;
        end
      end
    end
  end

  // Select address, data and direction of the two candidates
  always_comb begin
    a_g0  = '0;
    a_g1  = '0;
    d_g0  = '0;
    d_g1  = '0;
    we_g0 = 1'b0;
    we_g1 = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (PW'(i) == g0) begin
        a_g0  = req_addr[i*AW +: AW];
        d_g0  = req_wdata[i*DW +: DW];
        we_g0 = req_we[i];
      end
      if (PW'(i) == g1) begin
        a_g1  = req_addr[i*AW +: AW];
        d_g1  = req_wdata[i*DW +: DW];
        we_g1 = req_we[i];
      end
    end
  end

  // Same address with at least one write drops the second grant; no re-search
  assign conflict = (a_g0 == a_g1) && (we_g0 || we_g1);
  assign gnt0     = f0 && !RST;
  assign gnt1     = f1 && !conflict && !RST;

  // SRAM port drive; idle ports are fully zeroed
  always_comb begin
    CE0  = gnt0;
    WE0  = gnt0 && we_g0;
    A0   = gnt0 ? a_g0 : '0;
    D0   = gnt0 ? d_g0 : '0;
    WEM0 = WE0 ? '1 : '0;
    CE1  = gnt1;
    WE1  = gnt1 && we_g1;
    A1   = gnt1 ? a_g1 : '0;
    D1   = gnt1 ? d_g1 : '0;
    WEM1 = WE1 ? '1 : '0;
  end

  // Combinational ready: only the granted requesters see a handshake
  always_comb begin
    req_ready = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      req_ready[i] = (gnt0 && (g0 == PW'(i))) || (gnt1 && (g1 == PW'(i)));
    end
  end

  // Route SRAM read data to the owner tagged at the grant edge
  always_comb begin
    rsp_valid = '0;
    rsp_data  = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (v0 && !RST && (id0 == PW'(i))) begin
        rsp_valid[i]          = 1'b1;
        rsp_data[i*DW +: DW]  = Q0;
      end
      if (v1 && !RST && (id1 == PW'(i))) begin
        rsp_valid[i]          = 1'b1;
        rsp_data[i*DW +: DW]  = Q1;
      end
    end
  end

  // Round-robin pointer and read-response tags
  always_ff @(posedge CLK) begin
    if (RST) begin
      rr_ptr <= '0;
      v0     <= 1'b0;
      v1     <= 1'b0;
      id0    <= '0;
      id1    <= '0;
    end else begin
      v0  <= gnt0 && !we_g0;
      id0 <= g0;
      v1  <= gnt1 && !we_g1;
      id1 <= g1;
      if (gnt1) begin
        rr_ptr <= wrap(g1, 1);
      end else if (gnt0) begin
        rr_ptr <= wrap(g0, 1);
      end
    end
  end

endmodule

// File: tb/tb_sram_dp_arbiter.sv
// Directed bench for sram_dp_arbiter with a behavioural dual-port SRAM.
module tb_sram_dp_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req_valid, req_ready, req_we, rsp_valid;
  logic [39:0] req_addr;
  logic [63:0] req_wdata, rsp_data;
  logic        ce0, we0, ce1, we1;
  logic [9:0]  a0, a1;
  logic [15:0] d0, wem0, q0, d1, wem1, q1;
  logic [15:0] mem [1024];

  int n_tests;
  int n_fail;

  sram_dp_arbiter #(.NREQ(4), .AW(10), .DW(16)) dut (
    .CLK(clk), .RST(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .CE0(ce0), .A0(a0), .D0(d0), .WE0(we0), .WEM0(wem0), .Q0(q0),
    .CE1(ce1), .A1(a1), .D1(d1), .WE1(we1), .WEM1(wem1), .Q1(q1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM model: masked write on CE&WE, registered read data on CE&~WE
  always @(posedge clk) begin
    if (ce0) begin
      if (we0) mem[a0] <= (mem[a0] & ~wem0) | (d0 & wem0);
      else     q0 <= mem[a0];
    end
    if (ce1) begin
      if (we1) mem[a1] <= (mem[a1] & ~wem1) | (d1 & wem1);
      else     q1 <= mem[a1];
    end
  end

  typedef struct {
    logic [3:0]  valid;
    logic [3:0]  we;
    logic [39:0] addr;
    logic [63:0] wdata;
    logic [3:0]  ready;
    logic        ce0;
    logic [9:0]  a0;
    logic        we0;
    logic        ce1;
    logic [9:0]  a1;
    logic        we1;
    logic [3:0]  rspv;
    logic [63:0] rspd;
  } vec_t;

  localparam int NV = 16;
  vec_t vecs [NV];

  localparam logic [39:0] RDA = {10'h013, 10'h012, 10'h011, 10'h010};
  localparam logic [63:0] WDA = {16'hA003, 16'hA002, 16'hA001, 16'hA000};

  function automatic vec_t mk(
    input logic [3:0] valid, input logic [3:0] we,
    input logic [39:0] addr, input logic [63:0] wdata,
    input logic [3:0] ready,
    input logic c0, input logic [9:0] ad0, input logic w0,
    input logic c1, input logic [9:0] ad1, input logic w1,
    input logic [3:0] rspv, input logic [63:0] rspd);
    vec_t v;
    v.valid = valid; v.we = we; v.addr = addr; v.wdata = wdata;
    v.ready = ready; v.ce0 = c0; v.a0 = ad0; v.we0 = w0;
    v.ce1 = c1; v.a1 = ad1; v.we1 = w1; v.rspv = rspv; v.rspd = rspd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] valid, input logic [3:0] we,
                       input logic [39:0] addr, input logic [63:0] wdata);
    req_valid = valid;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    for (int i = 0; i < 1024; i++) mem[i] = 16'h0000;
    q0 = 16'h0000;
    q1 = 16'h0000;

    // Vector table: one cycle each, outputs sampled on the falling edge
    vecs[0]  = mk(4'hF, 4'h0, RDA, 64'h0, 4'b0011, 1, 10'h010, 0, 1, 10'h011, 0, 4'b0000, 64'h0);
    vecs[1]  = mk(4'b0100, 4'b0100, {10'h0, 10'h155, 20'h0}, {16'h0, 16'hBEEF, 32'h0},
                  4'b0100, 1, 10'h155, 1, 0, 10'h0, 0, 4'b0011, 64'h0);
    vecs[2]  = mk(4'b0100, 4'b0000, {10'h0, 10'h155, 20'h0}, 64'h0,
                  4'b0100, 1, 10'h155, 0, 0, 10'h0, 0, 4'b0000, 64'h0);
    vecs[3]  = mk(4'h0, 4'h0, 40'h0, 64'h0, 4'b0000, 0, 10'h0, 0, 0, 10'h0, 0,
                  4'b0100, {16'h0, 16'hBEEF, 32'h0});
    vecs[4]  = mk(4'hF, 4'hF, RDA, WDA, 4'b1001, 1, 10'h013, 1, 1, 10'h010, 1, 4'b0000, 64'h0);
    vecs[5]  = mk(4'hF, 4'hF, RDA, WDA, 4'b0110, 1, 10'h011, 1, 1, 10'h012, 1, 4'b0000, 64'h0);
    vecs[6]  = mk(4'b1000, 4'b1000, 40'h0, {16'h1234, 48'h0},
                  4'b1000, 1, 10'h000, 1, 0, 10'h0, 0, 4'b0000, 64'h0);
    vecs[7]  = mk(4'hF, 4'h0, RDA, 64'h0, 4'b0011, 1, 10'h010, 0, 1, 10'h011, 0, 4'b0000, 64'h0);
    vecs[8]  = mk(4'hF, 4'h0, RDA, 64'h0, 4'b1100, 1, 10'h012, 0, 1, 10'h013, 0,
                  4'b0011, {32'h0, 16'hA001, 16'hA000});
    vecs[9]  = mk(4'hF, 4'h0, RDA, 64'h0, 4'b0011, 1, 10'h010, 0, 1, 10'h011, 0,
                  4'b1100, {16'hA003, 16'hA002, 32'h0});
    vecs[10] = mk(4'h0, 4'h0, 40'h0, 64'h0, 4'b0000, 0, 10'h0, 0, 0, 10'h0, 0,
                  4'b0011, {32'h0, 16'hA001, 16'hA000});
    vecs[11] = mk(4'b1000, 4'h0, RDA, 64'h0, 4'b1000, 1, 10'h013, 0, 0, 10'h0, 0, 4'b0000, 64'h0);
    vecs[12] = mk(4'b0011, 4'b0001, {20'h0, 10'h3FF, 10'h3FF}, {48'h0, 16'h5A5A},
                  4'b0001, 1, 10'h3FF, 1, 0, 10'h0, 0, 4'b1000, {16'hA003, 48'h0});
    vecs[13] = mk(4'b0010, 4'h0, {20'h0, 10'h3FF, 10'h0}, 64'h0,
                  4'b0010, 1, 10'h3FF, 0, 0, 10'h0, 0, 4'b0000, 64'h0);
    vecs[14] = mk(4'b1010, 4'h0, 40'h0, 64'h0, 4'b1010, 1, 10'h000, 0, 1, 10'h000, 0,
                  4'b0010, {32'h0, 16'h5A5A, 16'h0});
    vecs[15] = mk(4'h0, 4'h0, 40'h0, 64'h0, 4'b0000, 0, 10'h0, 0, 0, 10'h0, 0,
                  4'b1010, {16'h1234, 16'h0, 16'h1234, 16'h0});

    // Reset held two cycles with every requester valid
    rst = 1'b1;
    drive(4'hF, 4'h0, RDA, 64'h0);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk($sformatf("rst%0d.ready", c), 64'(req_ready), 64'h0);
      chk($sformatf("rst%0d.ce", c), 64'({ce1, ce0, we1, we0}), 64'h0);
      chk($sformatf("rst%0d.rspv", c), 64'(rsp_valid), 64'h0);
      chk($sformatf("rst%0d.rspd", c), rsp_data, 64'h0);
    end
    @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].valid, vecs[i].we, vecs[i].addr, vecs[i].wdata);
      @(negedge clk);
      chk($sformatf("v%0d.ready", i), 64'(req_ready), 64'(vecs[i].ready));
      chk($sformatf("v%0d.ce0", i), 64'(ce0), 64'(vecs[i].ce0));
      chk($sformatf("v%0d.a0", i), 64'(a0), 64'(vecs[i].a0));
      chk($sformatf("v%0d.we0", i), 64'(we0), 64'(vecs[i].we0));
      chk($sformatf("v%0d.ce1", i), 64'(ce1), 64'(vecs[i].ce1));
      chk($sformatf("v%0d.a1", i), 64'(a1), 64'(vecs[i].a1));
      chk($sformatf("v%0d.we1", i), 64'(we1), 64'(vecs[i].we1));
      chk($sformatf("v%0d.rspv", i), 64'(rsp_valid), 64'(vecs[i].rspv));
      chk($sformatf("v%0d.rspd", i), rsp_data, vecs[i].rspd);
      @(posedge clk);
      #1;
    end

    // Reset mid-operation: read by req3 dropped, write by req0 committed
    drive(4'b1001, 4'b0001, {10'h013, 20'h0, 10'h222}, {48'h0, 16'h7777});
    @(negedge clk);
    chk("mr.grant", 64'(req_ready), 64'b1001);
    chk("mr.ports", 64'({ce0, a0, we0, ce1, a1, we1}), 64'({1'b1, 10'h013, 1'b0, 1'b1, 10'h222, 1'b1}));
    @(posedge clk);
    #1;
    rst = 1'b1;
    drive(4'h0, 4'h0, 40'h0, 64'h0);
    @(negedge clk);
    chk("mr.rspv_in_rst", 64'(rsp_valid), 64'h0);
    chk("mr.rspd_in_rst", rsp_data, 64'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("mr.rspv_after", 64'(rsp_valid), 64'h0);
    @(posedge clk);
    #1 drive(4'b0001, 4'b0000, {30'h0, 10'h222}, 64'h0);
    @(negedge clk);
    chk("mr.read_grant", 64'(req_ready), 64'b0001);
    @(posedge clk);
    #1 drive(4'h0, 4'h0, 40'h0, 64'h0);
    @(negedge clk);
    chk("mr.read_rspv", 64'(rsp_valid), 64'b0001);
    chk("mr.read_rspd", rsp_data, {48'h0, 16'h7777});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
